pipe_stage_elastic: RTL and testbench
=====================================

# pipe_stage_elastic

Parametrised elastic pipeline stage register that replaces fixed stall/clear stage registers between any two pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB). Carries a packed WIDTH-bit payload under a valid/ready handshake, supports flush and bubble insertion, and can optionally be built as a two-entry skid buffer so upstream ready is registered. Also keeps a saturating stall-cycle counter for performance debug.

## Interface
- WIDTH, 32, payload width in bits (≥1)
- CLEAR_VALUE, {WIDTH{1'b0}}, payload value for empty slots, bubbles and reset (all-zero = NOP instruction word)
- CNT_W, 16, width of stall counter (≥2)

- clk  in  1  clock, all state updates on rising edge
- CLR  in  1  synchronous active-high reset
- FLUSH  in  1  synchronous discard of all held entries (branch/exception redirect)
- in_valid  in  1  upstream payload valid
- in_ready  out  1  stage can accept this cycle
- in_bubble  in  1  when an entry is accepted with this high, payload stored as CLEAR_VALUE
- in_data  in  WIDTH  upstream payload
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts head this cycle
- out_data  out  WIDTH  head payload; CLEAR_VALUE whenever out_valid=0
- occupancy  out  2  entries held (0..1 base, 0..2 with skid)
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Accepted payload = in_bubble ? CLEAR_VALUE : in_data. A bubble is a valid entry (out_valid=1), not a dropped one.
- Strict FIFO order; no payload reordering, duplication or loss except by FLUSH/CLR.
- Base build: states EMPTY, FULL.
  - EMPTY: in_fire → FULL.
  - FULL: out_fire & !in_fire → EMPTY; out_fire & in_fire → FULL with new payload; neither → hold.
  - in_ready = (state==EMPTY | out_ready) & !FLUSH (combinational pass-through of out_ready).
- FLUSH=1: next state EMPTY, all slots ← CLEAR_VALUE; in_ready forced 0 so no upstream transfer occurs that cycle; out_fire that cycle still counts as delivered to downstream (downstream owns its own flush).
- CLR=1: as FLUSH plus stall_cnt ← 0; CLR has priority over everything.
- stall_cnt increments when out_valid & !out_ready & !FLUSH & !CLR; saturates at all-ones; cleared only by CLR.
- occupancy reflects registered state (0 EMPTY, 1 ONE/FULL, 2 TWO).

## Timing
- Reset values (cycle after CLR): out_valid=0, out_data=CLEAR_VALUE, occupancy=0, stall_cnt=0, in_ready=1 (if FLUSH=0).
- Latency: in_fire at edge N → out_valid=1 with that payload after edge N (1 cycle), both builds.
- Throughput: 1 entry/cycle sustained when out_ready held high, both builds.
- Simultaneous in_fire and out_fire at occupancy 1 → occupancy stays 1, head replaced (base) or advanced (skid).
- CLR or FLUSH mid-stream: entries present before the edge are gone after it; payload presented with in_valid that cycle is not accepted and must be re-presented by upstream.
- stall_cnt at all-ones stays at all-ones on further stalls.

## Configuration
- PIPE_STAGE_SKID_EN defined: two-entry skid buffer, states EMPTY, ONE, TWO.
  - in_ready = (state != TWO) & !FLUSH; depends only on registered state and FLUSH, never on out_ready.
  - ONE: in_fire & !out_fire → TWO; out_fire & !in_fire → EMPTY; both → ONE (new payload becomes head).
  - TWO: out_fire → ONE (second entry promoted to head); no in_fire possible.
  - occupancy reaches 2.
- Not defined: base single-entry build above; occupancy never exceeds 1; no skid storage instantiated.

## Test plan
- CLR for 2 cycles, then idle → out_valid=0, out_data=0, occupancy=0, stall_cnt=0, in_ready=1.
- Stream 0x11,0x22,0x33 with out_ready=1 → outputs appear one cycle later in order, one per cycle, occupancy=1 throughout.
- Accept 0xAAAA with in_bubble=1 → out_valid=1, out_data=0x0 next cycle.
- out_ready=0 for 5 cycles with valid head 0x55 → stall_cnt=5, head held at 0x55; skid build: second in 0x66 accepted, in_ready=0 after, occupancy=2, then out_ready=1 yields 0x55 then 0x66.
- FLUSH with occupancy≥1 and in_valid=1 (0x77) → next cycle occupancy=0, out_valid=0, 0x77 never appears at output.
- Force 2^CNT_W+3 stall cycles (CNT_W=2 build) → stall_cnt stays 3; CLR → 0.

Source files
------------

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: elastic stage register between two pipeline stages.
// Carries a WIDTH-bit payload under a valid/ready handshake. It supports
// flush and bubble insertion, and keeps a saturating stall-cycle counter.
// Build option PIPE_STAGE_SKID_EN: a two-entry skid buffer with a
// registered in_ready. Without it, the stage holds a single entry and
// passes out_ready through to in_ready combinationally.
module pipe_stage_elastic #(
   parameter int unsigned      WIDTH       = 32,
   parameter logic [WIDTH-1:0] CLEAR_VALUE = {WIDTH{1'b0}},
   parameter int unsigned      CNT_W       = 16
) (
   input  logic             clk,
   input  logic             CLR,
   input  logic             FLUSH,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_bubble,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy,
   output logic [CNT_W-1:0] stall_cnt
);

   // The state encoding doubles as the occupancy count.
   localparam logic [1:0] S_EMPTY = 2'd0;
   localparam logic [1:0] S_ONE   = 2'd1;
   localparam logic [1:0] S_TWO   = 2'd2;

   logic [1:0]       state;
   logic [WIDTH-1:0] head;
   logic [WIDTH-1:0] acc_data;
   logic             in_fire;
   logic             out_fire;

   // A bubble is stored as a valid entry carrying CLEAR_VALUE.
   assign acc_data  = in_bubble ? CLEAR_VALUE : in_data;
   assign out_valid = (state != S_EMPTY);
   assign out_data  = out_valid ? head : CLEAR_VALUE;
   assign occupancy = state;
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic [WIDTH-1:0] skid;

   // Ready comes from registered state only. This breaks the
   // combinational ready path from downstream back to upstream.
   assign in_ready = (state != S_TWO) & ~FLUSH & ~CLR;

   // Two-entry FIFO: head is presented downstream, skid catches the
   // entry that arrives while the head is stalled.
   always_ff @(posedge clk) begin
      if (CLR || FLUSH) begin
         state <= S_EMPTY;
         head  <= CLEAR_VALUE;
         skid  <= CLEAR_VALUE;
      end else begin
         case (state)
            S_EMPTY: begin
               if (in_fire) begin
                  state <= S_ONE;
                  head  <= acc_data;
               end
            end
            S_ONE: begin
               case ({in_fire, out_fire})
                  2'b10: begin
                     state <= S_TWO;
                     skid  <= acc_data;
                  end
                  2'b01: begin
                     state <= S_EMPTY;
                     head  <= CLEAR_VALUE;
                  end
                  2'b11: head <= acc_data;
                  default: ;
               endcase
            end
            S_TWO: begin
               if (out_fire) begin
                  state <= S_ONE;
                  head  <= skid;
                  skid  <= CLEAR_VALUE;
               end
            end
            default: begin
               state <= S_EMPTY;
               head  <= CLEAR_VALUE;
               skid  <= CLEAR_VALUE;
            end
         endcase
      end
   end
`else
   // Ready passes out_ready straight through, so a full stage can be
   // refilled in the same cycle that its head leaves.
   assign in_ready = ((state == S_EMPTY) | out_ready) & ~FLUSH & ~CLR;

   // Single slot. A new entry overwrites the head whenever accepted,
   // which is legal only when the stage is empty or draining.
   always_ff @(posedge clk) begin
      if (CLR || FLUSH) begin
         state <= S_EMPTY;
         head  <= CLEAR_VALUE;
      end else if (in_fire) begin
         state <= S_ONE;
         head  <= acc_data;
      end else if (out_fire) begin
         state <= S_EMPTY;
         head  <= CLEAR_VALUE;
      end
   end
`endif

   // Count cycles where the head is valid but blocked downstream.
   // The counter saturates, and only CLR resets it.
   always_ff @(posedge clk) begin
      if (CLR)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && !FLUSH && !(&stall_cnt))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic. It drives a default-sized
// instance plus a narrow CNT_W=2 instance for the saturation check.
// Expectations follow PIPE_STAGE_SKID_EN when it is defined.
module tb_pipe_stage_elastic;

   logic        clk = 1'b0;
   logic        CLR = 1'b0;
   logic        FLUSH = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic        in_bubble = 1'b0;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [1:0]  occupancy;
   logic [15:0] stall_cnt;

   logic        in_valid2 = 1'b0;
   logic        in_ready2;
   logic [7:0]  in_data2 = '0;
   logic        out_valid2;
   logic        out_ready2 = 1'b0;
   logic [7:0]  out_data2;
   logic [1:0]  occupancy2;
   logic [1:0]  stall_cnt2;

   int ncmp = 0;
   int nerr = 0;

   always #5 clk = ~clk;

   pipe_stage_elastic #(.WIDTH(32), .CNT_W(16)) dut (
      .clk(clk), .CLR(CLR), .FLUSH(FLUSH),
      .in_valid(in_valid), .in_ready(in_ready), .in_bubble(in_bubble),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   pipe_stage_elastic #(.WIDTH(8), .CNT_W(2)) dut2 (
      .clk(clk), .CLR(CLR), .FLUSH(1'b0),
      .in_valid(in_valid2), .in_ready(in_ready2), .in_bubble(1'b0),
      .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_data(out_data2), .occupancy(occupancy2), .stall_cnt(stall_cnt2)
   );

   // Advance one rising edge and settle past it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      CLR = 1'b1;
      step();
      step();
      CLR = 1'b0;
      step();
      ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
      ncmp++; if (out_data !== 32'h0) begin nerr++; $display("FAIL reset_data got=%h exp=0", out_data); end
      ncmp++; if (occupancy !== 2'd0) begin nerr++; $display("FAIL reset_occ got=%0d exp=0", occupancy); end
      ncmp++; if (stall_cnt !== 16'd0) begin nerr++; $display("FAIL reset_stall got=%0d exp=0", stall_cnt); end
      ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
      ncmp++; if (stall_cnt2 !== 2'd0) begin nerr++; $display("FAIL reset_stall2 got=%0d exp=0", stall_cnt2); end
   endtask

   task automatic test_stream();
      logic [31:0] vec [3];
      vec[0] = 32'h11; vec[1] = 32'h22; vec[2] = 32'h33;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         in_data = vec[i];
         step();
         ncmp++; if (out_valid !== 1'b1 || out_data !== vec[i]) begin nerr++; $display("FAIL stream_%0d got=%0b/%h exp=1/%h", i, out_valid, out_data, vec[i]); end
         ncmp++; if (occupancy !== 2'd1) begin nerr++; $display("FAIL stream_occ_%0d got=%0d exp=1", i, occupancy); end
      end
      in_valid = 1'b0;
      step();
      ncmp++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin nerr++; $display("FAIL stream_drain got=%0b/%0d exp=0/0", out_valid, occupancy); end
   endtask

   task automatic test_bubble();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_bubble = 1'b1;
      in_data   = 32'hAAAA;
      step();
      in_valid  = 1'b0;
      in_bubble = 1'b0;
      ncmp++; if (out_valid !== 1'b1 || out_data !== 32'h0) begin nerr++; $display("FAIL bubble got=%0b/%h exp=1/0", out_valid, out_data); end
      out_ready = 1'b1;
      step();
      ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL bubble_drain got=%0b exp=0", out_valid); end
   endtask

   task automatic test_stall();
      out_ready = 1'b1;
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h55;
      step();
      ncmp++; if (out_data !== 32'h55) begin nerr++; $display("FAIL stall_load got=%h exp=55", out_data); end
`ifdef PIPE_STAGE_SKID_EN
      in_data = 32'h66;
      #1;
      ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL skid_ready_one got=%0b exp=1", in_ready); end
      step();
      in_valid = 1'b0;
      ncmp++; if (in_ready !== 1'b0 || occupancy !== 2'd2) begin nerr++; $display("FAIL skid_two got=%0b/%0d exp=0/2", in_ready, occupancy); end
      for (int i = 0; i < 4; i++) step();
`else
      in_valid = 1'b0;
      #1;
      ncmp++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL base_ready_full got=%0b exp=0", in_ready); end
      for (int i = 0; i < 5; i++) step();
`endif
      ncmp++; if (stall_cnt !== 16'd5) begin nerr++; $display("FAIL stall_cnt got=%0d exp=5", stall_cnt); end
      ncmp++; if (out_valid !== 1'b1 || out_data !== 32'h55) begin nerr++; $display("FAIL stall_hold got=%0b/%h exp=1/55", out_valid, out_data); end
      out_ready = 1'b1;
`ifndef PIPE_STAGE_SKID_EN
      #1;
      ncmp++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL base_ready_pass got=%0b exp=1", in_ready); end
`endif
      step();
`ifdef PIPE_STAGE_SKID_EN
      ncmp++; if (out_data !== 32'h66 || occupancy !== 2'd1) begin nerr++; $display("FAIL skid_second got=%h/%0d exp=66/1", out_data, occupancy); end
      step();
`endif
      ncmp++; if (out_valid !== 1'b0 || stall_cnt !== 16'd5) begin nerr++; $display("FAIL stall_drain got=%0b/%0d exp=0/5", out_valid, stall_cnt); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h99;
      step();
      FLUSH   = 1'b1;
      in_data = 32'h77;
      #1;
      ncmp++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL flush_ready got=%0b exp=0", in_ready); end
      step();
      FLUSH    = 1'b0;
      in_valid = 1'b0;
      ncmp++; if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_data !== 32'h0) begin nerr++; $display("FAIL flush_empty got=%0d/%0b/%h exp=0/0/0", occupancy, out_valid, out_data); end
      ncmp++; if (stall_cnt !== 16'd5) begin nerr++; $display("FAIL flush_stall got=%0d exp=5", stall_cnt); end
      out_ready = 1'b1;
      step();
      ncmp++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_no77 got=%0b/%h exp=0", out_valid, out_data); end
   endtask

   task automatic test_saturate();
      out_ready2 = 1'b0;
      in_valid2  = 1'b1;
      in_data2   = 8'hC3;
      step();
      in_valid2 = 1'b0;
      for (int i = 0; i < 3; i++) step();
      ncmp++; if (stall_cnt2 !== 2'd3) begin nerr++; $display("FAIL sat_reach got=%0d exp=3", stall_cnt2); end
      for (int i = 0; i < 4; i++) step();
      ncmp++; if (stall_cnt2 !== 2'd3 || out_data2 !== 8'hC3) begin nerr++; $display("FAIL sat_hold got=%0d/%h exp=3/c3", stall_cnt2, out_data2); end
      CLR = 1'b1;
      step();
      CLR = 1'b0;
      ncmp++; if (stall_cnt2 !== 2'd0 || stall_cnt !== 16'd0) begin nerr++; $display("FAIL sat_clr got=%0d/%0d exp=0/0", stall_cnt2, stall_cnt); end
      ncmp++; if (out_valid2 !== 1'b0 || out_data2 !== 8'h0) begin nerr++; $display("FAIL sat_clr_empty got=%0b/%h exp=0/0", out_valid2, out_data2); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_bubble();
      test_stall();
      test_flush();
      test_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
